mem_arbiter: RTL and testbench

Shares one single-port, non-pipelined memory between the processor's instruction-fetch port and its data load/store port. It grants at most one access per free memory slot and tracks the single outstanding read. It returns read data to the port that issued it and guards instruction fetch against starvation by back-to-back data accesses. It sits between PROCESSOR (InstrAddr/InstrMem and MemAddr/MemData/WriteData/MemRead/MemWrite) and memory. A de-asserted grant is the processor's stall.

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store.
// Tracks the one outstanding read and bounds how long a fetch can be starved.
module mem_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 32,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 2
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic          IGnt,
    output logic          IValid,
    output logic [DW-1:0] IData,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWData,
    output logic          DGnt,
    output logic          DValid,
    output logic [DW-1:0] DRData,
    output logic [AW-1:0] MemAddr,
    output logic          MemReadEn,
    output logic          MemWriteEn,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData
);

    localparam logic [0:0] IDLE       = 1'b0;
    localparam logic [0:0] WAIT       = 1'b1;
    localparam logic       OWN_I      = 1'b0;
    localparam logic       OWN_D      = 1'b1;
    localparam logic [1:0] CNT_INIT   = 2'(RD_LAT - 1);
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    logic [0:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic [2:0] starve_q, starve_d;

    logic mem_free;
    logic i_win;
    logic i_gnt;
    logic d_gnt;
    logic rd_grant;
    logic rd_done;

    // Data wins ties until the waiting fetch has seen STARVE_LIMIT data grants.
    always_comb begin
        mem_free = nReset && ((state_q == IDLE) || (cnt_q == 2'd0));
        i_win    = IReq && (!DReq || (starve_q == STARVE_MAX));
        i_gnt    = mem_free && i_win;
        d_gnt    = mem_free && DReq && !i_win;
        rd_grant = i_gnt || (d_gnt && !DWe);
        rd_done  = nReset && (state_q == WAIT) && (cnt_q == 2'd0);
    end

    always_comb begin
        IGnt       = i_gnt;
        DGnt       = d_gnt;
        MemReadEn  = rd_grant;
        MemWriteEn = d_gnt && DWe;
        MemWData   = DWData;
        if (i_gnt) begin
            MemAddr = IAddr;
        end else if (d_gnt) begin
            MemAddr = DAddr;
        end else begin
            MemAddr = '0;
        end
        IValid = rd_done && (owner_q == OWN_I);
        DValid = rd_done && (owner_q == OWN_D);
        IData  = IValid ? MemRData : '0;
        DRData = DValid ? MemRData : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        if (rd_grant) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
            owner_d = i_gnt ? OWN_I : OWN_D;
        end else if ((state_q == WAIT) && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end else begin
            state_d = IDLE;
        end

        starve_d = starve_q;
        if (i_gnt || !IReq) begin
            starve_d = 3'd0;
        end else if (d_gnt) begin
            starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX : starve_q + 3'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            owner_q  <= OWN_I;
            starve_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances with RD_LAT 1, 2 and 3 share
// the same stimulus, each backed by its own latency-matched memory model.
module tb_mem_arbiter;

    logic        clock;
    logic        n_reset;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;

    logic        i_gnt     [3];
    logic        i_valid   [3];
    logic [31:0] i_data    [3];
    logic        d_gnt     [3];
    logic        d_valid   [3];
    logic [31:0] d_rdata   [3];
    logic [15:0] mem_addr  [3];
    logic        mem_re    [3];
    logic        mem_we    [3];
    logic [31:0] mem_wdata [3];

    int checks   = 0;
    int failures = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instance g has RD_LAT = g+1; memory word n initially holds 0xC0DE0000 | n.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] mem  [64];
        logic [31:0] pipe [3];

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
            for (int i = 0; i < 3; i++) pipe[i] = 32'h0;
        end

        always @(posedge clock) begin
            if (mem_we[g]) mem[mem_addr[g][7:2]] <= mem_wdata[g];
            pipe[0] <= mem_re[g] ? mem[mem_addr[g][7:2]] : 32'h0;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        mem_arbiter #(.AW(16), .DW(32), .RD_LAT(g + 1), .STARVE_LIMIT(2)) u_dut (
            .Clock      (clock),
            .nReset     (n_reset),
            .IReq       (i_req),
            .IAddr      (i_addr),
            .IGnt       (i_gnt[g]),
            .IValid     (i_valid[g]),
            .IData      (i_data[g]),
            .DReq       (d_req),
            .DWe        (d_we),
            .DAddr      (d_addr),
            .DWData     (d_wdata),
            .DGnt       (d_gnt[g]),
            .DValid     (d_valid[g]),
            .DRData     (d_rdata[g]),
            .MemAddr    (mem_addr[g]),
            .MemReadEn  (mem_re[g]),
            .MemWriteEn (mem_we[g]),
            .MemWData   (mem_wdata[g]),
            .MemRData   (pipe[g])
        );
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        step();
        step();
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        i_req   = 1'b1;
        d_req   = 1'b1;
        d_we    = 1'b0;
        i_addr  = 16'h0004;
        d_addr  = 16'h0008;
        step();
        step();
        @(negedge clock);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({i_gnt[g], d_gnt[g], i_valid[g], d_valid[g], mem_re[g], mem_we[g]} !== 6'b0) begin
                failures++;
                $display("[TB] FAIL reset_strobes dut%0d: got %b expected 000000", g,
                         {i_gnt[g], d_gnt[g], i_valid[g], d_valid[g], mem_re[g], mem_we[g]});
            end
            checks++;
            if ({i_data[g], d_rdata[g], mem_addr[g]} !== 80'h0) begin
                failures++;
                $display("[TB] FAIL reset_data dut%0d: got %h expected 0", g,
                         {i_data[g], d_rdata[g], mem_addr[g]});
            end
        end
        i_req   = 1'b0;
        d_req   = 1'b0;
        step();
        n_reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({i_gnt[1], d_gnt[1], i_valid[1], d_valid[1], mem_re[1], mem_we[1], mem_addr[1]} !== 22'h0) begin
            failures++;
            $display("[TB] FAIL idle_outputs: got %h expected 0",
                     {i_gnt[1], d_gnt[1], i_valid[1], d_valid[1], mem_re[1], mem_we[1], mem_addr[1]});
        end
        step();
    endtask

    task automatic test_fetch_lat2();
        do_reset();
        i_req  = 1'b1;
        i_addr = 16'h0004;
        @(negedge clock);
        checks++;
        if ({i_gnt[1], mem_re[1], mem_addr[1]} !== {1'b1, 1'b1, 16'h0004}) begin
            failures++;
            $display("[TB] FAIL fetch_grant: got %h expected %h",
                     {i_gnt[1], mem_re[1], mem_addr[1]}, {1'b1, 1'b1, 16'h0004});
        end
        step();
        i_req  = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0008;
        @(negedge clock);
        checks++;
        if ({i_gnt[1], d_gnt[1], i_valid[1]} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL busy_no_grant: got %b expected 000", {i_gnt[1], d_gnt[1], i_valid[1]});
        end
        step();
        @(negedge clock);
        checks++;
        if ({i_valid[1], i_data[1], d_gnt[1]} !== {1'b1, 32'hC0DE_0001, 1'b1}) begin
            failures++;
            $display("[TB] FAIL fetch_data: got %h expected %h",
                     {i_valid[1], i_data[1], d_gnt[1]}, {1'b1, 32'hC0DE_0001, 1'b1});
        end
        step();
        d_req = 1'b0;
        step();
        @(negedge clock);
        checks++;
        if ({d_valid[1], d_rdata[1], i_valid[1]} !== {1'b1, 32'hC0DE_0002, 1'b0}) begin
            failures++;
            $display("[TB] FAIL load_after_fetch: got %h expected %h",
                     {d_valid[1], d_rdata[1], i_valid[1]}, {1'b1, 32'hC0DE_0002, 1'b0});
        end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            i_req  = (k < 3);
            i_addr = 16'(k * 4);
            @(negedge clock);
            if (k < 3) begin
                checks++;
                if (i_gnt[0] !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL b2b_grant cycle%0d: got %b expected 1", k, i_gnt[0]);
                end
            end
            if (k > 0) begin
                checks++;
                if ({i_valid[0], i_data[0]} !== {1'b1, 32'hC0DE_0000 | 32'(k - 1)}) begin
                    failures++;
                    $display("[TB] FAIL b2b_data cycle%0d: got %h expected %h", k,
                             {i_valid[0], i_data[0]}, {1'b1, 32'hC0DE_0000 | 32'(k - 1)});
                end
            end
            step();
        end
        i_req = 1'b0;
    endtask

    task automatic test_write_read();
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0010;
        d_wdata = 32'h1234_5678;
        @(negedge clock);
        checks++;
        if ({d_gnt[1], mem_we[1], mem_re[1], mem_addr[1], mem_wdata[1]} !==
            {1'b1, 1'b1, 1'b0, 16'h0010, 32'h1234_5678}) begin
            failures++;
            $display("[TB] FAIL write_grant: got %h expected %h",
                     {d_gnt[1], mem_we[1], mem_re[1], mem_addr[1], mem_wdata[1]},
                     {1'b1, 1'b1, 1'b0, 16'h0010, 32'h1234_5678});
        end
        step();
        d_we = 1'b0;
        @(negedge clock);
        checks++;
        if ({d_gnt[1], mem_re[1], mem_we[1]} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL read_after_write: got %b expected 110", {d_gnt[1], mem_re[1], mem_we[1]});
        end
        step();
        d_req = 1'b0;
        @(negedge clock);
        checks++;
        if ({d_valid[1], i_valid[1]} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL early_valid: got %b expected 00", {d_valid[1], i_valid[1]});
        end
        step();
        @(negedge clock);
        checks++;
        if ({d_valid[1], d_rdata[1], i_valid[1], i_data[1]} !== {1'b1, 32'h1234_5678, 1'b0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL write_readback: got %h expected %h",
                     {d_valid[1], d_rdata[1], i_valid[1], i_data[1]}, {1'b1, 32'h1234_5678, 1'b0, 32'h0});
        end
        step();
    endtask

    task automatic test_starvation();
        logic [5:0] exp_i;
        logic [5:0] exp_d;
        exp_i = 6'b100100;
        exp_d = 6'b011011;
        do_reset();
        i_req   = 1'b1;
        i_addr  = 16'h0020;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0030;
        d_wdata = 32'hA5A5_0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            checks++;
            if ({i_gnt[0], d_gnt[0]} !== {exp_i[k], exp_d[k]}) begin
                failures++;
                $display("[TB] FAIL starve_cycle%0d: got IGnt/DGnt %b expected %b", k,
                         {i_gnt[0], d_gnt[0]}, {exp_i[k], exp_d[k]});
            end
            step();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        logic [6:0] exp_ig;
        logic [6:0] exp_dg;
        logic [6:0] exp_dv;
        logic [6:0] exp_iv;
        exp_ig = 7'b0001000;
        exp_dg = 7'b0000001;
        exp_dv = 7'b0001000;
        exp_iv = 7'b1000000;
        do_reset();
        i_req  = 1'b1;
        i_addr = 16'h0008;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h000C;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            checks++;
            if ({i_gnt[2], d_gnt[2], d_valid[2], i_valid[2]} !== {exp_ig[k], exp_dg[k], exp_dv[k], exp_iv[k]}) begin
                failures++;
                $display("[TB] FAIL simul_cycle%0d: got IGnt/DGnt/DValid/IValid %b expected %b", k,
                         {i_gnt[2], d_gnt[2], d_valid[2], i_valid[2]}, {exp_ig[k], exp_dg[k], exp_dv[k], exp_iv[k]});
            end
            if (exp_dv[k]) begin
                checks++;
                if (d_rdata[2] !== 32'hC0DE_0003) begin
                    failures++;
                    $display("[TB] FAIL simul_ddata: got %h expected c0de0003", d_rdata[2]);
                end
            end
            if (exp_iv[k]) begin
                checks++;
                if (i_data[2] !== 32'hC0DE_0002) begin
                    failures++;
                    $display("[TB] FAIL simul_idata: got %h expected c0de0002", i_data[2]);
                end
            end
            step();
            if (k == 0) d_req = 1'b0;
            if (k == 3) i_req = 1'b0;
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        i_req  = 1'b1;
        i_addr = 16'h0004;
        @(negedge clock);
        checks++;
        if (i_gnt[2] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL inflight_grant: got %b expected 1", i_gnt[2]);
        end
        step();
        i_req   = 1'b0;
        n_reset = 1'b0;
        step();
        n_reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if ({i_valid[2], d_valid[2]} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL dropped_read cycle%0d: got %b expected 00", k, {i_valid[2], d_valid[2]});
            end
            step();
        end
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0014;
        @(negedge clock);
        checks++;
        if ({d_gnt[2], mem_re[2], mem_addr[2]} !== {1'b1, 1'b1, 16'h0014}) begin
            failures++;
            $display("[TB] FAIL post_reset_grant: got %h expected %h",
                     {d_gnt[2], mem_re[2], mem_addr[2]}, {1'b1, 1'b1, 16'h0014});
        end
        step();
        d_req = 1'b0;
        step();
        step();
        @(negedge clock);
        checks++;
        if ({d_valid[2], d_rdata[2], i_valid[2]} !== {1'b1, 32'hC0DE_0005, 1'b0}) begin
            failures++;
            $display("[TB] FAIL post_reset_data: got %h expected %h",
                     {d_valid[2], d_rdata[2], i_valid[2]}, {1'b1, 32'hC0DE_0005, 1'b0});
        end
        step();
    endtask

    initial begin
        n_reset = 1'b0;
        i_req   = 1'b0;
        i_addr  = 16'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 16'h0;
        d_wdata = 32'h0;
        step();
        test_reset();
        test_fetch_lat2();
        test_back_to_back();
        test_write_read();
        test_starvation();
        test_simultaneous();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
